// File: rtl/pause_pkg.sv
// pause_pkg: shared types and constants for the pause controller.
// FSM state enum, option bit indices, fade level width and divide shift.
package pause_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ARM     = 2'd1,
    PAUSED  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int OPT_OSD   = 0;
  localparam int OPT_DIM   = 1;
  localparam int OPT_FSYNC = 2;

  localparam int LVL_W         = 4;
  localparam int LVL_DIV_SHIFT = 4;

endpackage

// File: rtl/pause_scale.sv
// pause_scale: one colour channel scaled by (16 - level) / 16.
// Ports: c (pixel in), level (fade level), y (scaled pixel, combinational).
module pause_scale
  import pause_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]     c,
  input  logic [LVL_W-1:0] level,
  output logic [W-1:0]     y
);

  logic [W+4:0] gain;
  logic [W+4:0] prod;
  logic [W+4:0] shf;

  // gain is 16..8, so level 0 gives c*16 >> 4 == c exactly
  assign gain = (W+5)'(5'd16 - {1'b0, level});
  assign prod = (W+5)'(c) * gain;
  assign shf  = prod >> LVL_DIV_SHIFT;
  assign y    = shf[W-1:0];

endmodule

// File: rtl/pause_ctrl.sv
// pause_ctrl: merges user/OSD/request pause sources, optional vblank-
// aligned entry/exit, and a burn-in fade of the RGB path while paused.
// Ports: clk_sys, reset, user_button, pause_request, req_mask, options,
// OSD_STATUS, vblank, r/g/b in; pause_cpu, paused_by, dim_level, rgb_out.
module pause_ctrl
  import pause_pkg::*;
#(
  parameter int RW          = 8,
  parameter int GW          = 8,
  parameter int BW          = 8,
  parameter int CLKSPD      = 12,
  parameter int NREQ        = 2,
  parameter int DEBOUNCE_MS = 10,
  parameter int DIM_MS      = 10000,
  parameter int FADE_MS     = 100,
  parameter int DIM_MAX     = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  user_button,
  input  logic [NREQ-1:0]       pause_request,
  input  logic [NREQ-1:0]       req_mask,
  input  logic [2:0]            options,
  input  logic                  OSD_STATUS,
  input  logic                  vblank,
  input  logic [RW-1:0]         r,
  input  logic [GW-1:0]         g,
  input  logic [BW-1:0]         b,
  output logic                  pause_cpu,
  output logic [NREQ+1:0]       paused_by,
  output logic [LVL_W-1:0]      dim_level,
  output logic [RW+GW+BW-1:0]   rgb_out
);

  localparam int PRE_MAX = CLKSPD * 1000 - 1;
  localparam int PRE_W   = $clog2(PRE_MAX + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int DIM_W   = $clog2(DIM_MS + 1);
  localparam int FADE_W  = $clog2(FADE_MS + 1);

  logic [PRE_W-1:0]  pre_cnt;
  logic              ms_tick;

  logic              btn_s1;
  logic              btn_s2;
  logic              btn_acc;
  logic [DEB_W-1:0]  deb_cnt;
  logic              user_toggle;

  logic [NREQ-1:0]   req_hit;
  logic              osd_hit;
  logic              cond;
  logic              fsync;
  logic              vb_q;
  logic              vb_rise;
  state_t            state;

  logic              dim_on;
  logic [DIM_W-1:0]  dim_ms;
  logic [FADE_W-1:0] fade_cnt;

  logic [RW-1:0]     r_sc;
  logic [GW-1:0]     g_sc;
  logic [BW-1:0]     b_sc;

  assign ms_tick = (pre_cnt == PRE_W'(PRE_MAX));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // btn_acc is the debounced level; it only follows btn_s2 after
  // DEBOUNCE_MS consecutive ms ticks of disagreement
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      btn_s1      <= 1'b0;
      btn_s2      <= 1'b0;
      btn_acc     <= 1'b0;
      deb_cnt     <= '0;
      user_toggle <= 1'b0;
    end else begin
      btn_s1 <= user_button;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_acc) begin
        deb_cnt <= '0;
      end else if (ms_tick) begin
        if (deb_cnt == DEB_W'(DEBOUNCE_MS - 1)) begin
          deb_cnt <= '0;
          btn_acc <= btn_s2;
          if (btn_s2) begin
            user_toggle <= ~user_toggle;
          end
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end
    end
  end

  assign req_hit   = pause_request & req_mask;
  assign osd_hit   = OSD_STATUS & options[OPT_OSD];
  assign paused_by = {req_hit, osd_hit, user_toggle};
  assign cond      = |paused_by;
  assign fsync     = options[OPT_FSYNC];
  assign vb_rise   = vblank & ~vb_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vb_q <= 1'b0;
    end else begin
      vb_q <= vblank;
    end
  end

  // cond changes take priority over a coincident vblank edge
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      pause_cpu <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (cond) begin
            if (fsync) begin
              state <= ARM;
            end else begin
              state     <= PAUSED;
              pause_cpu <= 1'b1;
            end
          end
        end
        ARM: begin
          if (!cond) begin
            state <= RUN;
          end else if (vb_rise) begin
            state     <= PAUSED;
            pause_cpu <= 1'b1;
          end
        end
        PAUSED: begin
          if (!cond) begin
            if (fsync) begin
              state <= RELEASE;
            end else begin
              state     <= RUN;
              pause_cpu <= 1'b0;
            end
          end
        end
        RELEASE: begin
          if (cond) begin
            state <= PAUSED;
          end else if (vb_rise) begin
            state     <= RUN;
            pause_cpu <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          pause_cpu <= 1'b0;
        end
      endcase
    end
  end

  assign dim_on = pause_cpu & options[OPT_DIM];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dim_ms    <= '0;
      fade_cnt  <= '0;
      dim_level <= '0;
    end else if (!dim_on) begin
      dim_ms    <= '0;
      fade_cnt  <= '0;
      dim_level <= '0;
    end else if (ms_tick) begin
      if (dim_ms != DIM_W'(DIM_MS)) begin
        dim_ms <= dim_ms + DIM_W'(1);
      end else if (dim_level != LVL_W'(DIM_MAX)) begin
        if (fade_cnt == FADE_W'(FADE_MS - 1)) begin
          fade_cnt  <= '0;
          dim_level <= dim_level + LVL_W'(1);
        end else begin
          fade_cnt <= fade_cnt + FADE_W'(1);
        end
      end
    end
  end

  pause_scale #(.W(RW)) u_scale_r (
    .c     (r),
    .level (dim_level),
    .y     (r_sc)
  );

  pause_scale #(.W(GW)) u_scale_g (
    .c     (g),
    .level (dim_level),
    .y     (g_sc)
  );

  pause_scale #(.W(BW)) u_scale_b (
    .c     (b),
    .level (dim_level),
    .y     (b_sc)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rgb_out <= '0;
    end else begin
      rgb_out <= {r_sc, g_sc, b_sc};
    end
  end

endmodule

// File: tb/tb_pause_ctrl.sv
// tb_pause_ctrl: directed self-checking bench for pause_ctrl.
// Small timing parameters; pixel path checked through a scoreboard queue.
module tb_pause_ctrl;

  localparam int NREQ = 2;

  logic            clk_sys = 1'b0;
  logic            reset = 1'b1;
  logic            user_button = 1'b0;
  logic [NREQ-1:0] pause_request = '0;
  logic [NREQ-1:0] req_mask = '0;
  logic [2:0]      options = '0;
  logic            OSD_STATUS = 1'b0;
  logic            vblank = 1'b0;
  logic [7:0]      r = '0;
  logic [7:0]      g = '0;
  logic [7:0]      b = '0;
  logic            pause_cpu;
  logic [NREQ+1:0] paused_by;
  logic [3:0]      dim_level;
  logic [23:0]     rgb_out;

  int vectors = 0;
  int errs = 0;
  logic [23:0] sb_q[$];

  always #5 clk_sys = ~clk_sys;

  pause_ctrl #(
    .RW(8), .GW(8), .BW(8), .CLKSPD(1), .NREQ(NREQ),
    .DEBOUNCE_MS(2), .DIM_MS(5), .FADE_MS(1), .DIM_MAX(8)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .user_button   (user_button),
    .pause_request (pause_request),
    .req_mask      (req_mask),
    .options       (options),
    .OSD_STATUS    (OSD_STATUS),
    .vblank        (vblank),
    .r             (r),
    .g             (g),
    .b             (b),
    .pause_cpu     (pause_cpu),
    .paused_by     (paused_by),
    .dim_level     (dim_level),
    .rgb_out       (rgb_out)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] scl(input logic [7:0] c, input int lvl);
    int v;
    v = (int'(c) * (16 - lvl)) / 16;
    return v[7:0];
  endfunction

  task automatic pix(input logic [7:0] rr, input logic [7:0] gg,
                     input logic [7:0] bb, input int lvl, input string tag);
    logic [23:0] e;
    r = rr;
    g = gg;
    b = bb;
    sb_q.push_back({scl(rr, lvl), scl(gg, lvl), scl(bb, lvl)});
    step();
    e = sb_q.pop_front();
    chk(tag, 32'(rgb_out), 32'(e));
  endtask

  task automatic wait_pause(input logic val, input int bound, output int n);
    n = 0;
    while (pause_cpu !== val && n < bound) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int prev;
    int extra;

    #12;
    chk("rst_pause", 32'(pause_cpu), 0);
    chk("rst_dim", 32'(dim_level), 0);
    chk("rst_rgb", 32'(rgb_out), 0);
    chk("rst_pby", 32'(paused_by), 0);
    pause_request = 2'b01;
    req_mask = 2'b01;
    #1;
    chk("rst_pby_req", 32'(paused_by), 32'h4);
    pause_request = '0;
    req_mask = '0;
    @(negedge clk_sys);
    reset = 1'b0;
    step();

    pix(8'h12, 8'h34, 8'h56, 0, "pass_a");
    pix(8'hFF, 8'h00, 8'h80, 0, "pass_b");
    for (int i = 0; i < 4; i++) begin
      pix(8'($urandom), 8'($urandom), 8'($urandom), 0,
          $sformatf("pass_rnd%0d", i));
    end

    user_button = 1'b1;
    step();
    user_button = 1'b0;
    steps(3000);
    chk("glitch_pause", 32'(pause_cpu), 0);
    chk("glitch_user", 32'(paused_by[0]), 0);

    user_button = 1'b1;
    wait_pause(1'b1, 2600, n);
    chk("btn_on", 32'(pause_cpu), 1);
    chk("btn_lat", 32'(n >= 1000 && n <= 2010), 1);
    chk("btn_pby", 32'(paused_by), 32'h1);
    steps(3000 - n);
    user_button = 1'b0;
    steps(3000);
    chk("btn_hold", 32'(pause_cpu), 1);
    user_button = 1'b1;
    wait_pause(1'b0, 2600, n);
    chk("btn_off", 32'(pause_cpu), 0);
    chk("btn_off_pby", 32'(paused_by), 0);
    steps(1000);
    user_button = 1'b0;
    steps(3000);

    OSD_STATUS = 1'b1;
    step();
    chk("osd_ignored", 32'(pause_cpu), 0);
    options = 3'b001;
    #1;
    chk("osd_pby", 32'(paused_by), 32'h2);
    step();
    chk("osd_pause", 32'(pause_cpu), 1);
    OSD_STATUS = 1'b0;
    step();
    chk("osd_resume", 32'(pause_cpu), 0);

    options = 3'b100;
    req_mask = 2'b01;
    pause_request = 2'b01;
    steps(10);
    chk("arm_hold", 32'(pause_cpu), 0);
    vblank = 1'b1;
    step();
    chk("arm_vb", 32'(pause_cpu), 1);
    vblank = 1'b0;
    step();
    pause_request = '0;
    steps(4);
    chk("rel_wait", 32'(pause_cpu), 1);
    pause_request = 2'b01;
    vblank = 1'b1;
    step();
    chk("rel_reassert", 32'(pause_cpu), 1);
    vblank = 1'b0;
    steps(3);
    chk("rel_stay", 32'(pause_cpu), 1);
    pause_request = '0;
    steps(3);
    vblank = 1'b1;
    step();
    chk("rel_vb", 32'(pause_cpu), 0);
    vblank = 1'b0;
    step();

    pause_request = 2'b01;
    step();
    chk("arm2_in", 32'(pause_cpu), 0);
    pause_request = '0;
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    steps(3);
    chk("arm_drop", 32'(pause_cpu), 0);

    req_mask = '0;
    pause_request = 2'b01;
    #1;
    chk("mask_pby", 32'(paused_by), 0);
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    steps(3);
    chk("mask_pause", 32'(pause_cpu), 0);
    pause_request = '0;

    options = 3'b010;
    req_mask = 2'b11;
    pause_request = 2'b10;
    r = 8'hFF;
    g = 8'hFF;
    b = 8'hFF;
    step();
    chk("dim_pause", 32'(pause_cpu), 1);
    chk("dim_pby", 32'(paused_by), 32'h8);
    n = 0;
    while (dim_level == 4'd0 && n < 7000) begin
      step();
      n++;
    end
    chk("dim_first", 32'(dim_level), 1);
    chk("dim_delay", 32'(n >= 5000 && n <= 6002), 1);
    prev = 1;
    extra = 0;
    for (int lvl = 2; lvl <= 8; lvl++) begin
      n = extra;
      while (dim_level == 4'(prev) && n < 1100) begin
        step();
        n++;
      end
      chk($sformatf("fade_step%0d", lvl), 32'(n), 1000);
      chk($sformatf("fade_lvl%0d", lvl), 32'(dim_level), 32'(lvl));
      prev = lvl;
      extra = 0;
      if (lvl == 4 || lvl == 8) begin
        pix(8'hFF, 8'hFF, 8'hFF, lvl, $sformatf("fade_rgb%0d", lvl));
        extra = 1;
      end
      if (lvl == 4) chk("lvl4_bf", 32'(rgb_out[23:16]), 32'hBF);
    end
    chk("lvl8_7f", 32'(rgb_out[7:0]), 32'h7F);
    steps(2000);
    chk("dim_hold", 32'(dim_level), 8);

    pause_request = '0;
    pix(8'hFF, 8'h40, 8'h01, 8, "drop_e1");
    chk("drop_pause", 32'(pause_cpu), 0);
    pix(8'hFF, 8'h40, 8'h01, 8, "drop_e2");
    chk("drop_dim", 32'(dim_level), 0);
    pix(8'hFF, 8'h40, 8'h01, 0, "drop_e3");

    options = 3'b100;
    vblank = 1'b0;
    user_button = 1'b1;
    n = 0;
    while (paused_by[0] !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk("arm_user", 32'(paused_by[0]), 1);
    user_button = 1'b0;
    step();
    chk("arm_pre", 32'(pause_cpu), 0);
    pix(8'h55, 8'hAA, 8'h33, 0, "arm_pix");
    #2;
    reset = 1'b1;
    #1;
    chk("arm_rst_pause", 32'(pause_cpu), 0);
    chk("arm_rst_rgb", 32'(rgb_out), 0);
    chk("arm_rst_pby", 32'(paused_by), 0);
    #3;
    reset = 1'b0;
    steps(3);
    chk("arm_post_pause", 32'(pause_cpu), 0);
    chk("arm_post_pby", 32'(paused_by), 0);

    options = 3'b000;
    user_button = 1'b1;
    wait_pause(1'b1, 3000, n);
    chk("pau_on", 32'(pause_cpu), 1);
    user_button = 1'b0;
    pix(8'h55, 8'hAA, 8'h33, 0, "pau_pix");
    #2;
    reset = 1'b1;
    #1;
    chk("pau_rst_pause", 32'(pause_cpu), 0);
    chk("pau_rst_rgb", 32'(rgb_out), 0);
    #3;
    reset = 1'b0;
    steps(5);
    chk("pau_post_pause", 32'(pause_cpu), 0);
    chk("pau_post_pby", 32'(paused_by), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
